// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    MISALIGNED = 2'd1,
    TIMEOUT    = 2'd2
  } fetch_fault_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_INCR   = 4;

endpackage

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch: owns pc_cur/pc_old, issues one imem req per fetch and latches the word.
// Request one cycle after fetch_start, result one cycle after ack; commands outside IDLE are dropped.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int              TIMEOUT_CYCLES = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_start,
  input  logic            pc_write,
  input  logic [XLEN-1:0] pc_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_old,
  output logic            busy,
  output logic            fault,
  output logic [1:0]      fault_cause
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  fetch_state_t    state_q;
  fetch_fault_t    cause_q;
  logic [7:0]      wait_cnt_q;
  logic [7:0]      wait_cnt_d;
  logic [XLEN-1:0] pc_cur_q;
  logic [XLEN-1:0] pc_cur_d;
  logic [XLEN-1:0] pc_old_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] imem_addr_q;
  logic            imem_req_q;
  logic            instr_valid_q;
  logic            busy_q;
  logic            fault_q;

  assign wait_cnt_d = wait_cnt_q + 8'd1;
  // Sequential increment wraps naturally at 2^XLEN.
  assign pc_cur_d   = pc_cur_q + XLEN'(PC_INCR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cause_q       <= NONE;
      wait_cnt_q    <= '0;
      pc_cur_q      <= RESET_PC;
      pc_old_q      <= '0;
      instr_q       <= XLEN'(NOP_INSTR);
      imem_addr_q   <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      instr_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pc_write) begin
            pc_cur_q <= pc_target;
          end else if (fetch_start) begin
            if (pc_cur_q[1:0] != 2'b00) begin
              fault_q <= 1'b1;
              cause_q <= MISALIGNED;
              state_q <= FAULT;
            end else begin
              imem_req_q  <= 1'b1;
              imem_addr_q <= pc_cur_q;
              busy_q      <= 1'b1;
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          imem_req_q <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          // An ack in the limit cycle still wins over the timeout.
          if (imem_ack) begin
            instr_q       <= imem_rdata;
            pc_old_q      <= pc_cur_q;
            pc_cur_q      <= pc_cur_d;
            instr_valid_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else if (wait_cnt_d == TIMEOUT_LIM) begin
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= 1'b1;
            cause_q    <= TIMEOUT;
            busy_q     <= 1'b0;
            state_q    <= FAULT;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc_cur      = pc_cur_q;
  assign pc_old      = pc_old_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

endmodule
